// File: rtl/axi_seq_pkg.sv
// Shared types, bus constants and the byte-lane strobe helper for the AXI write beat sequencer.
package axi_seq_pkg;

   typedef enum logic [1:0] {
      FIXED = 2'b00,
      INCR  = 2'b01,
      WRAP  = 2'b10,
      RSVD  = 2'b11
   } burst_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int BUS_BYTES = 8;
   localparam int LANE_W    = 3;

   // Full-width beats always enable every lane; narrower beats are clipped at lane 7.
   function automatic logic [BUS_BYTES-1:0] strb_of(input logic [LANE_W-1:0] lane,
                                                    input logic [2:0]        size);
      logic [2*BUS_BYTES-1:0] mask;
      if (size >= 3'd3) begin
         return '1;
      end
      mask = ((16'd1 << (5'd1 << size)) - 16'd1) << lane;
      return mask[BUS_BYTES-1:0];
   endfunction

endpackage

// File: rtl/axi_beat_addr_next.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// WRAP folding is only built when AXI_WRAP_BURST_EN is defined.
module axi_beat_addr_next
   import axi_seq_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        size,
   input  burst_t            burst,
   output logic [ADDR_W-1:0] next_addr
`ifdef AXI_WRAP_BURST_EN
   ,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] container
`endif
);

   logic [ADDR_W-1:0] bytes;
   logic [ADDR_W-1:0] inc_addr;

   assign bytes    = ADDR_W'(1) << size;
   assign inc_addr = (addr & ~(bytes - ADDR_W'(1))) + bytes;

   always_comb begin
      next_addr = inc_addr;
      if (burst == FIXED) begin
         next_addr = addr;
      end
`ifdef AXI_WRAP_BURST_EN
      else if (burst == WRAP && inc_addr == base + container) begin
         next_addr = base;
      end
`endif
   end

endmodule

// File: rtl/axi_wr_beat_sequencer.sv
// Per-beat AXI write burst sequencer: command decode, beat counter, FSM and registered beat outputs.
// Optional WRAP sequencing is enabled with AXI_WRAP_BURST_EN; otherwise WRAP runs as INCR with ERR.
module axi_wr_beat_sequencer
   import axi_seq_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int LEN_W  = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic [ADDR_W-1:0] CMD_ADDR,
   input  logic [2:0]        CMD_SIZE,
   input  logic [LEN_W-1:0]  CMD_LEN,
   input  logic [1:0]        CMD_BURST,
   output logic              BEAT_VALID,
   input  logic              BEAT_READY,
   output logic [ADDR_W-1:0] BEAT_ADDR,
   output logic [7:0]        BEAT_STRB,
   output logic              BEAT_LAST,
   output logic              ERR
);

   localparam int SPAN_W = ADDR_W + LEN_W + 4;

   state_t             state_reg, state_next;
   logic [ADDR_W-1:0]  addr_reg;
   logic [7:0]         strb_reg;
   logic               last_reg;
   logic [LEN_W-1:0]   remaining_reg;
   logic [1:0]         size_reg;
   burst_t             burst_reg;
   logic               err_reg;

   logic               beat_hs;
   logic               cmd_accept;
   logic [1:0]         size_eff;
   burst_t             burst_eff;
   logic               err_next;
   logic [ADDR_W-1:0]  cmd_bytes;
   logic [ADDR_W-1:0]  cmd_aligned;
   logic [SPAN_W-1:0]  incr_end;
   logic [ADDR_W-1:0]  addr_next;

`ifdef AXI_WRAP_BURST_EN
   logic [ADDR_W-1:0]  base_reg, container_reg;
   logic [ADDR_W-1:0]  cmd_base, cmd_container;
   logic               wrap_ok;
`endif

   assign BEAT_VALID = (state_reg == RUN);
   assign BEAT_ADDR  = addr_reg;
   assign BEAT_STRB  = strb_reg;
   assign BEAT_LAST  = last_reg;
   assign ERR        = err_reg;

   assign beat_hs    = BEAT_VALID & BEAT_READY;
   assign CMD_READY  = (state_reg == IDLE) | (beat_hs & last_reg);
   assign cmd_accept = CMD_VALID & CMD_READY;

   // Command decode: clamp size, legalise the burst type and flag anything we had to change.
   always_comb begin
      size_eff    = (CMD_SIZE > 3'd3) ? 2'd3 : CMD_SIZE[1:0];
      err_next    = (CMD_SIZE > 3'd3);
      cmd_bytes   = ADDR_W'(1) << size_eff;
      cmd_aligned = CMD_ADDR & ~(cmd_bytes - ADDR_W'(1));
      incr_end    = SPAN_W'(cmd_aligned) + ((SPAN_W'(CMD_LEN) + SPAN_W'(1)) << size_eff);
`ifdef AXI_WRAP_BURST_EN
      cmd_container = ADDR_W'((SPAN_W'(CMD_LEN) + SPAN_W'(1)) << size_eff);
      cmd_base      = CMD_ADDR & ~(cmd_container - ADDR_W'(1));
      wrap_ok       = (CMD_LEN == LEN_W'(1) || CMD_LEN == LEN_W'(3) ||
                       CMD_LEN == LEN_W'(7) || CMD_LEN == LEN_W'(15)) &&
                      ((CMD_ADDR & (cmd_bytes - ADDR_W'(1))) == '0);
`endif
      burst_eff = INCR;
      case (CMD_BURST)
         2'b00: burst_eff = FIXED;
         2'b01: burst_eff = INCR;
         2'b10: begin
`ifdef AXI_WRAP_BURST_EN
            if (wrap_ok) begin
               burst_eff = WRAP;
            end else begin
               err_next = 1'b1;
            end
`else
            err_next = 1'b1;
`endif
         end
         default: err_next = 1'b1;
      endcase
      if (burst_eff == INCR && incr_end > (SPAN_W'(1) << ADDR_W)) begin
         err_next = 1'b1;
      end
   end

   axi_beat_addr_next #(
      .ADDR_W    (ADDR_W)
   ) u_addr_next (
      .addr      (addr_reg),
      .size      (size_reg),
      .burst     (burst_reg),
      .next_addr (addr_next)
`ifdef AXI_WRAP_BURST_EN
      ,
      .base      (base_reg),
      .container (container_reg)
`endif
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (cmd_accept) state_next = RUN;
         RUN:  if (beat_hs && last_reg && !cmd_accept) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // A new command always wins: it can only be accepted while idle or on the LAST handshake.
   always_ff @(posedge CLK) begin
      if (RST) begin
         addr_reg      <= '0;
         strb_reg      <= '0;
         last_reg      <= 1'b0;
         remaining_reg <= '0;
         size_reg      <= '0;
         burst_reg     <= FIXED;
         err_reg       <= 1'b0;
`ifdef AXI_WRAP_BURST_EN
         base_reg      <= '0;
         container_reg <= '0;
`endif
      end else begin
         err_reg <= cmd_accept & err_next;
         if (cmd_accept) begin
            addr_reg      <= CMD_ADDR;
            strb_reg      <= strb_of(CMD_ADDR[LANE_W-1:0], {1'b0, size_eff});
            last_reg      <= (CMD_LEN == '0);
            remaining_reg <= CMD_LEN;
            size_reg      <= size_eff;
            burst_reg     <= burst_eff;
`ifdef AXI_WRAP_BURST_EN
            base_reg      <= cmd_base;
            container_reg <= cmd_container;
`endif
         end else if (beat_hs) begin
            addr_reg      <= addr_next;
            strb_reg      <= strb_of(addr_next[LANE_W-1:0], {1'b0, size_reg});
            last_reg      <= (remaining_reg == LEN_W'(1));
            remaining_reg <= remaining_reg - LEN_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_axi_wr_beat_sequencer.sv
// Scoreboard bench for axi_wr_beat_sequencer: directed commands push expected beats/ERR, a monitor pops and compares.
module tb_axi_wr_beat_sequencer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        CMD_VALID = 1'b0;
   logic        CMD_READY;
   logic [11:0] CMD_ADDR = '0;
   logic [2:0]  CMD_SIZE = '0;
   logic [7:0]  CMD_LEN = '0;
   logic [1:0]  CMD_BURST = '0;
   logic        BEAT_VALID;
   logic        BEAT_READY = 1'b1;
   logic [11:0] BEAT_ADDR;
   logic [7:0]  BEAT_STRB;
   logic        BEAT_LAST;
   logic        ERR;

   typedef struct packed {
      logic [11:0] addr;
      logic [7:0]  strb;
      logic        last;
   } beat_t;

   beat_t exp_q[$];
   logic  err_q[$];
   int    vectors = 0;
   int    miscompares = 0;

   axi_wr_beat_sequencer #(.ADDR_W(12), .LEN_W(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .CMD_VALID  (CMD_VALID),
      .CMD_READY  (CMD_READY),
      .CMD_ADDR   (CMD_ADDR),
      .CMD_SIZE   (CMD_SIZE),
      .CMD_LEN    (CMD_LEN),
      .CMD_BURST  (CMD_BURST),
      .BEAT_VALID (BEAT_VALID),
      .BEAT_READY (BEAT_READY),
      .BEAT_ADDR  (BEAT_ADDR),
      .BEAT_STRB  (BEAT_STRB),
      .BEAT_LAST  (BEAT_LAST),
      .ERR        (ERR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic exp_beat(input logic [11:0] a, input logic [7:0] s, input logic l);
      beat_t b;
      b.addr = a;
      b.strb = s;
      b.last = l;
      exp_q.push_back(b);
   endtask

   task automatic issue(input logic [11:0] a, input logic [2:0] s, input logic [7:0] l,
                        input logic [1:0] b, input logic e);
      int n;
      err_q.push_back(e);
      CMD_ADDR  = a;
      CMD_SIZE  = s;
      CMD_LEN   = l;
      CMD_BURST = b;
      CMD_VALID = 1'b1;
      n = 0;
      @(negedge CLK);
      while (!CMD_READY && n < 200) begin
         @(negedge CLK);
         n++;
      end
      if (!CMD_READY) begin
         vectors++;
         miscompares++;
         $display("FAIL cmd_accept_timeout: got CMD_READY=0 expected 1 within 200 cycles");
      end
      @(posedge CLK);
      #1 CMD_VALID = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge CLK);
         n++;
      end
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: got %0d beats outstanding expected 0", exp_q.size());
      end
      repeat (2) @(posedge CLK);
      #1;
   endtask

   // Monitor: pops expected beats on each handshake, checks ERR the cycle after accept, checks hold under stall.
   initial begin
      logic        err_pending;
      logic        exp_err;
      logic        hold_armed;
      logic [20:0] hold_snap;
      beat_t       b;
      err_pending = 1'b0;
      exp_err     = 1'b0;
      hold_armed  = 1'b0;
      hold_snap   = '0;
      forever begin
         @(negedge CLK);
         if (err_pending) begin
            check("err_pulse", {31'd0, ERR}, {31'd0, exp_err});
            err_pending = 1'b0;
         end
         if (!RST) begin
            if (hold_armed) begin
               check("hold_valid", {31'd0, BEAT_VALID}, 32'd1);
               check("hold_beat", {11'd0, BEAT_ADDR, BEAT_STRB, BEAT_LAST}, {11'd0, hold_snap});
            end
            hold_armed = BEAT_VALID && !BEAT_READY;
            hold_snap  = {BEAT_ADDR, BEAT_STRB, BEAT_LAST};
            if (BEAT_VALID && BEAT_READY) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL beat_unexpected: got addr=%0h strb=%0h last=%0b expected no beat",
                           BEAT_ADDR, BEAT_STRB, BEAT_LAST);
               end else begin
                  b = exp_q.pop_front();
                  check("beat_addr", {20'd0, BEAT_ADDR}, {20'd0, b.addr});
                  check("beat_strb", {24'd0, BEAT_STRB}, {24'd0, b.strb});
                  check("beat_last", {31'd0, BEAT_LAST}, {31'd0, b.last});
               end
            end
            if (CMD_VALID && CMD_READY && err_q.size() != 0) begin
               exp_err     = err_q.pop_front();
               err_pending = 1'b1;
            end
         end else begin
            hold_armed = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200us");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      check("rst_beat_valid", {31'd0, BEAT_VALID}, 32'd0);
      check("rst_beat_addr", {20'd0, BEAT_ADDR}, 32'd0);
      check("rst_beat_strb", {24'd0, BEAT_STRB}, 32'd0);
      check("rst_beat_last", {31'd0, BEAT_LAST}, 32'd0);
      check("rst_err", {31'd0, ERR}, 32'd0);
      check("rst_cmd_ready", {31'd0, CMD_READY}, 32'd1);
      @(posedge CLK);
      #1;

      // INCR unaligned start
      exp_beat(12'h003, 8'h78, 1'b0);
      exp_beat(12'h004, 8'hF0, 1'b0);
      exp_beat(12'h008, 8'h0F, 1'b1);
      issue(12'h003, 3'd2, 8'd2, 2'b01, 1'b0);
      drain();

      // WRAP
`ifdef AXI_WRAP_BURST_EN
      exp_beat(12'h038, 8'hFF, 1'b0);
      exp_beat(12'h020, 8'hFF, 1'b0);
      exp_beat(12'h028, 8'hFF, 1'b0);
      exp_beat(12'h030, 8'hFF, 1'b1);
      issue(12'h038, 3'd3, 8'd3, 2'b10, 1'b0);
`else
      exp_beat(12'h038, 8'hFF, 1'b0);
      exp_beat(12'h040, 8'hFF, 1'b0);
      exp_beat(12'h048, 8'hFF, 1'b0);
      exp_beat(12'h050, 8'hFF, 1'b1);
      issue(12'h038, 3'd3, 8'd3, 2'b10, 1'b1);
`endif
      drain();

      // INCR with a stall, then FIXED presented at the LAST handshake
      exp_beat(12'h100, 8'hFF, 1'b0);
      exp_beat(12'h108, 8'hFF, 1'b0);
      exp_beat(12'h110, 8'hFF, 1'b0);
      exp_beat(12'h118, 8'hFF, 1'b1);
      issue(12'h100, 3'd3, 8'd3, 2'b01, 1'b0);
      @(posedge CLK);
      #1 BEAT_READY = 1'b0;
      repeat (5) @(posedge CLK);
      #1 BEAT_READY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_beat(12'h105, 8'h20, (i == 3));
      end
      issue(12'h105, 3'd0, 8'd3, 2'b00, 1'b0);
      check("b2b_first_valid", {31'd0, BEAT_VALID}, 32'd1);
      check("b2b_first_addr", {20'd0, BEAT_ADDR}, 32'h105);
      drain();

      // INCR crossing the 4KB page
      exp_beat(12'hFF8, 8'hFF, 1'b0);
      exp_beat(12'h000, 8'hFF, 1'b1);
      issue(12'hFF8, 3'd3, 8'd1, 2'b01, 1'b1);
      drain();

      // Oversized SIZE clamped to 8 bytes
      exp_beat(12'h010, 8'hFF, 1'b1);
      issue(12'h010, 3'd5, 8'd0, 2'b01, 1'b1);
      drain();

      // Reserved burst type runs as INCR
      exp_beat(12'h020, 8'h0F, 1'b0);
      exp_beat(12'h024, 8'hF0, 1'b1);
      issue(12'h020, 3'd2, 8'd1, 2'b11, 1'b1);
      drain();

      // WRAP with illegal length runs as INCR
      exp_beat(12'h044, 8'hF0, 1'b0);
      exp_beat(12'h048, 8'h0F, 1'b0);
      exp_beat(12'h04C, 8'hF0, 1'b1);
      issue(12'h044, 3'd2, 8'd2, 2'b10, 1'b1);
      drain();

      // Reset during beat 2 of an 8-beat INCR: burst dropped, no LAST
      exp_beat(12'h000, 8'hFF, 1'b0);
      issue(12'h000, 3'd3, 8'd7, 2'b01, 1'b0);
      @(posedge CLK);
      #1;
      BEAT_READY = 1'b0;
      RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      check("midrst_beat_valid", {31'd0, BEAT_VALID}, 32'd0);
      check("midrst_cmd_ready", {31'd0, CMD_READY}, 32'd1);
      BEAT_READY = 1'b1;
      repeat (12) @(posedge CLK);
      #1;
      drain();

      check("queues_empty", exp_q.size() + err_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
